seq_comp_word: RTL

- Parametrised bit/digit-serial magnitude comparator. Two operands A and B stream in DIGIT_W bits per accepted beat, for WORD_LEN beats per word.
- Supports LSB-first or MSB-first ordering and unsigned or two's-complement comparison.
- Raises a one-cycle done pulse and holds the gt/eq/lt verdict until the next word starts.
- Sits between serial link deserialisers and control logic that needs an ordering decision without assembling full words.

---
 rtl/seq_comp_pkg.sv | 34 +++
 rtl/seq_comp_digit.sv | 27 ++
 rtl/seq_comp_word.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seq_comp_pkg.sv
// Shared types for the digit-serial word comparator: verdict encoding, FSM
// states and the verdict-to-flag decode.
package seq_comp_pkg;

  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_GT = 2'd1,
    RES_LT = 2'd2
  } verdict_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } verdict_flags_t;

  // Unused encoding decodes to EQ so the flags stay one-hot.
  function automatic verdict_flags_t verdict_onehot(input verdict_e v);
    verdict_flags_t f;
    f = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
    case (v)
      RES_GT:  f = '{gt: 1'b1, eq: 1'b0, lt: 1'b0};
      RES_LT:  f = '{gt: 1'b0, eq: 1'b0, lt: 1'b1};
      default: f = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/seq_comp_digit.sv
// Combinational unsigned compare of one digit; flip_msb inverts the top bit
// of both operands so a sign-carrying digit orders as two's complement.
module seq_comp_digit #(
  parameter int unsigned DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               flip_msb,
  output logic               d_gt,
  output logic               d_eq,
  output logic               d_lt
);

  localparam logic [DIGIT_W-1:0] MSB_MASK = DIGIT_W'(1) << (DIGIT_W - 1);

  logic [DIGIT_W-1:0] a_x;
  logic [DIGIT_W-1:0] b_x;

  always_comb begin
    a_x  = a ^ (flip_msb ? MSB_MASK : '0);
    b_x  = b ^ (flip_msb ? MSB_MASK : '0);
    d_gt = (a_x > b_x);
    d_eq = (a_x == b_x);
    d_lt = (a_x < b_x);
  end

endmodule

// File: rtl/seq_comp_word.sv
// Digit-serial magnitude comparator: absorbs WORD_LEN digits per word,
// LSB- or MSB-first, unsigned or two's complement, with a held verdict.
module seq_comp_word
  import seq_comp_pkg::*;
#(
  parameter int unsigned DIGIT_W  = 1,
  parameter int unsigned WORD_LEN = 8,
  parameter int unsigned CNT_W    = $clog2(WORD_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               msb_first,
  input  logic               is_signed,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               busy,
  output logic               gt,
  output logic               eq,
  output logic               lt,
  output logic               done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_LEN - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             msb_first_q;
  logic             is_signed_q;
  verdict_e         verdict;

  logic             last_beat;
  logic             is_msd;
  logic             flip_msb;
  logic             d_gt;
  logic             d_eq;
  logic             d_lt;
  verdict_e         dig_res;
  verdict_e         verdict_nxt;

  // The sign-carrying digit is the first beat MSB-first, the last LSB-first.
  always_comb begin
    last_beat = (cnt == LAST_CNT);
    is_msd    = msb_first_q ? (cnt == '0) : last_beat;
    flip_msb  = is_signed_q & is_msd;
  end

  seq_comp_digit #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .a        (a),
    .b        (b),
    .flip_msb (flip_msb),
    .d_gt     (d_gt),
    .d_eq     (d_eq),
    .d_lt     (d_lt)
  );

  // LSB-first: latest difference wins. MSB-first: first difference is final.
  always_comb begin
    dig_res = RES_EQ;
    if (d_gt) begin
      dig_res = RES_GT;
    end else if (d_lt) begin
      dig_res = RES_LT;
    end
    verdict_nxt = verdict;
    if (msb_first_q) begin
      if (verdict == RES_EQ) begin
        verdict_nxt = dig_res;
      end
    end else if (!d_eq) begin
      verdict_nxt = dig_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      msb_first_q <= 1'b0;
      is_signed_q <= 1'b0;
      verdict     <= RES_EQ;
      busy        <= 1'b0;
      done        <= 1'b0;
      gt          <= 1'b0;
      eq          <= 1'b1;
      lt          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Start from either state; any digit offered alongside is dropped.
        state       <= ST_RUN;
        cnt         <= '0;
        msb_first_q <= msb_first;
        is_signed_q <= is_signed;
        verdict     <= RES_EQ;
        busy        <= 1'b1;
        {gt, eq, lt} <= verdict_onehot(RES_EQ);
      end else begin
        case (state)
          ST_RUN: begin
            if (in_valid) begin
              verdict      <= verdict_nxt;
              {gt, eq, lt} <= verdict_onehot(verdict_nxt);
              if (last_beat) begin
                state <= ST_IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
